// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port BRAM read arbiter: port ids, in-flight
// tracking entries and the one-hot port decode.
package mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef logic [0:0] port_id_t;

    typedef struct packed {
        logic     v;
        port_id_t id;
    } inflight_t;

    function automatic logic [NUM_PORTS-1:0] id_to_onehot(input port_id_t id);
        return (id == 1'b1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin grant between two requesters, with a bounded burst lock that
// keeps priority on the last granted port for at most MAX_LOCK grants.
module rr_lock_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] lock,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 gnt_valid,
    output port_id_t             gnt_id
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK);

    port_id_t      last_r;
    logic          prev_gnt_r;
    logic [CW-1:0] lock_cnt_r;

    logic          lock_hold_s;
    logic          gnt_v_s;
    port_id_t      gnt_id_s;
    logic [CW-1:0] lock_cnt_next_s;

    // Grant selection: burst lock first, then round-robin, then single requester.
    always_comb begin
        gnt_v_s     = 1'b0;
        gnt_id_s    = last_r;
        lock_hold_s = prev_gnt_r && lock[last_r] && req[last_r] && (lock_cnt_r < LOCK_LIMIT);
        if (rst) begin
            gnt_v_s = 1'b0;
        end else if (lock_hold_s) begin
            gnt_v_s  = 1'b1;
            gnt_id_s = last_r;
        end else if (req == 2'b11) begin
            gnt_v_s  = 1'b1;
            gnt_id_s = ~last_r;
        end else if (req[0]) begin
            gnt_v_s  = 1'b1;
            gnt_id_s = 1'b0;
        end else if (req[1]) begin
            gnt_v_s  = 1'b1;
            gnt_id_s = 1'b1;
        end else begin
            gnt_v_s = 1'b0;
        end
    end

    // Burst length of consecutive locked grants to the same port, saturating.
    always_comb begin
        lock_cnt_next_s = {CW{1'b0}};
        if (gnt_v_s && lock[gnt_id_s]) begin
            if (prev_gnt_r && (gnt_id_s == last_r)) begin
                if (lock_cnt_r >= LOCK_LIMIT) begin
                    lock_cnt_next_s = LOCK_LIMIT;
                end else begin
                    lock_cnt_next_s = lock_cnt_r + CW'(1);
                end
            end else begin
                lock_cnt_next_s = CW'(1);
            end
        end else begin
            lock_cnt_next_s = {CW{1'b0}};
        end
    end

    // Arbitration state: round-robin pointer, previous-grant flag, lock counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r     <= 1'b1;
            prev_gnt_r <= 1'b0;
            lock_cnt_r <= {CW{1'b0}};
        end else begin
            prev_gnt_r <= gnt_v_s;
            lock_cnt_r <= lock_cnt_next_s;
            if (gnt_v_s) begin
                last_r <= gnt_id_s;
            end else begin
                last_r <= last_r;
            end
        end
    end

    assign gnt       = gnt_v_s ? id_to_onehot(gnt_id_s) : 2'b00;
    assign gnt_valid = gnt_v_s;
    assign gnt_id    = gnt_id_s;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-read-port BRAM between the fetch path (port 0) and the
// PPU/DMA path (port 1), steering returned data back to the issuing port.
module bram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT      = 2,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [31:0]          addr0,
    input  logic [31:0]          addr1,
    input  logic [NUM_PORTS-1:0] lock,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 mem_read_en,
    output logic [31:0]          mem_addr,
    input  logic [31:0]          mem_q,
    output logic [NUM_PORTS-1:0] rvalid,
    output logic [31:0]          rdata,
    output logic                 busy
);

    logic      gnt_v_s;
    port_id_t  gnt_id_s;
    inflight_t pipe_r [LAT];
    logic      busy_s;

    rr_lock_arbiter #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_v_s),
        .gnt_id    (gnt_id_s)
    );

    // Address mux: granted port's address, zero when no read is issued.
    always_comb begin
        mem_addr = 32'h0000_0000;
        if (!gnt_v_s) begin
            mem_addr = 32'h0000_0000;
        end else if (gnt_id_s == 1'b1) begin
            mem_addr = addr1;
        end else begin
            mem_addr = addr0;
        end
    end

    // In-flight pipeline mirroring the BRAM latency; reset drops every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= '{v: 1'b0, id: 1'b0};
            end
        end else begin
            pipe_r[0] <= '{v: gnt_v_s, id: gnt_id_s};
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Any valid stage means a read is still outstanding.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy_s = busy_s | pipe_r[i].v;
        end
    end

    assign mem_read_en = gnt_v_s;
    assign rvalid      = pipe_r[LAT-1].v ? id_to_onehot(pipe_r[LAT-1].id) : 2'b00;
    assign rdata       = mem_q;
    assign busy        = busy_s;

endmodule
